// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: mode encodings and idle word.
// No ports; imported by spi_sync and spi_slave.
package spi_pkg;

    // {CPOL,CPHA}
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    localparam int MAX_WIDTH = 32;

    // Word shifted out when no transmit data has been supplied.
    function automatic logic [MAX_WIDTH-1:0] idle_word();
        return '1;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous pin.
// Ports: clk, rst (async high), d (raw pin), q (synchronized); RST_VAL = idle level.
module spi_sync
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, all four modes, oversampled by clk, one-entry tx holding register.
// Ports: clk, rst (async high); ss/sck/mosi pins in, miso out; mode {CPOL,CPHA};
// tx_data/tx_valid/tx_ready; rx_data/rx_valid; busy.
// With SPI_SLAVE_OVERRUN_EN: rx_ready in, overrun out, rx_valid held until rx_ready.
module spi_slave
    import spi_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ss,
    input  logic             sck,
    input  logic             mosi,
    output logic             miso,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
`ifdef SPI_SLAVE_OVERRUN_EN
    input  logic             rx_ready,
    output logic             overrun,
`endif
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] IDLE = WIDTH'(idle_word());

    logic ss_s, sck_s, mosi_s;

    spi_sync #(.RST_VAL(1'b1)) u_sync_ss   (.clk(clk), .rst(rst), .d(ss),   .q(ss_s));
    spi_sync #(.RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst(rst), .d(sck),  .q(sck_s));
    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

    logic             ss_prev_d, ss_prev_q;
    logic             sck_prev_d, sck_prev_q;
    spi_mode_e        mode_d, mode_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [WIDTH-1:0] tx_d, tx_q;
    logic [WIDTH-1:0] rx_sh_d, rx_sh_q;
    logic [WIDTH-1:0] rx_data_d, rx_data_q;
    logic             rx_valid_d, rx_valid_q;
    logic             miso_d, miso_q;
    logic [WIDTH-1:0] hold_d, hold_q;
    logic             hold_full_d, hold_full_q;
    logic             overrun_d, overrun_q;

    logic             ss_fall, ss_rise, lead, trail, sample, drive, word_done;
    logic [WIDTH-1:0] next_word, rx_next;

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Vacated positions fill with ones so an exhausted word idles high.
    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b1} : {1'b1, w[WIDTH-1:1]};
    endfunction

    always_comb begin
        ss_prev_d   = ss_s;
        sck_prev_d  = sck_s;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        tx_d        = tx_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        miso_d      = miso_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        overrun_d   = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
        rx_valid_d  = rx_valid_q && !rx_ready;
`else
        rx_valid_d  = 1'b0;
`endif

        ss_fall = ss_prev_q && !ss_s;
        ss_rise = !ss_prev_q && ss_s;

        // Edges only count inside a frame, never in the frame's first cycle.
        lead  = !ss_s && !ss_fall && (mode_q[1] ? (sck_prev_q && !sck_s)
                                                : (!sck_prev_q && sck_s));
        trail = !ss_s && !ss_fall && (mode_q[1] ? (!sck_prev_q && sck_s)
                                                : (sck_prev_q && !sck_s));
        sample    = mode_q[0] ? trail : lead;
        drive     = mode_q[0] ? lead : trail;
        word_done = sample && (cnt_q == LAST);

        next_word = hold_full_q ? hold_q : IDLE;
        rx_next   = MSB_FIRST ? {rx_sh_q[WIDTH-2:0], mosi_s}
                              : {mosi_s, rx_sh_q[WIDTH-1:1]};

        if (ss_fall) begin
            mode_d      = spi_mode_e'(mode);
            cnt_d       = '0;
            tx_d        = next_word;
            hold_full_d = 1'b0;
            // CPHA=0: the first bit must be valid before the first edge.
            if (!mode[0]) begin
                miso_d = out_bit(next_word);
                tx_d   = shift_out(next_word);
            end
        end else if (ss_rise) begin
            cnt_d  = '0;
            miso_d = 1'b1;
        end else begin
            if (drive) begin
                miso_d = out_bit(tx_q);
                tx_d   = shift_out(tx_q);
            end
            if (sample) begin
                rx_sh_d = rx_next;
                cnt_d   = word_done ? '0 : cnt_q + CNT_W'(1);
            end
            if (word_done) begin
                tx_d        = next_word;
                hold_full_d = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
                if (rx_valid_q && !rx_ready) begin
                    overrun_d = 1'b1;
                end else begin
                    rx_data_d  = rx_next;
                    rx_valid_d = 1'b1;
                end
`else
                rx_data_d  = rx_next;
                rx_valid_d = 1'b1;
`endif
            end
        end

        // Placed after the load so a same-cycle write lands in the emptied slot.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_prev_q   <= 1'b1;
            sck_prev_q  <= 1'b0;
            mode_q      <= MODE0;
            cnt_q       <= '0;
            tx_q        <= IDLE;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            miso_q      <= 1'b1;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            ss_prev_q   <= ss_prev_d;
            sck_prev_q  <= sck_prev_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            miso_q      <= miso_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            overrun_q   <= overrun_d;
        end
    end

    assign miso     = miso_q;
    assign tx_ready = !hold_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = !ss_s;
`ifdef SPI_SLAVE_OVERRUN_EN
    assign overrun  = overrun_q;
`else
    logic unused_ok;
    assign unused_ok = overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: 8-bit MSB-first instance and 12-bit LSB-first instance.
// Build with SPI_SLAVE_OVERRUN_EN defined to also exercise the overrun path.
module tb_spi_slave;

    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ss_a = 1'b1, ss_b = 1'b1, sck = 1'b0, mosi = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  tx_data_a = '0;
    logic        tx_valid_a = 1'b0;
    logic [11:0] tx_data_b = '0;
    logic        tx_valid_b = 1'b0;
    logic        miso_a, miso_b, tx_ready_a, tx_ready_b;
    logic        rx_valid_a, rx_valid_b, busy_a, busy_b;
    logic [7:0]  rx_data_a;
    logic [11:0] rx_data_b;
    logic        rx_ready_a = 1'b1, rx_ready_b = 1'b1;
    logic        ovr_a, ovr_b;
    logic        ack_a, ack_b;

    int total = 0;
    int bad = 0;
    int vcnt_a = 0, vcnt_b = 0, ovr_cnt = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    always #5 clk = ~clk;

    spi_slave #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .ss(ss_a), .sck(sck), .mosi(mosi), .miso(miso_a),
        .mode(mode), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a),
`ifdef SPI_SLAVE_OVERRUN_EN
        .rx_ready(rx_ready_a), .overrun(ovr_a),
`endif
        .busy(busy_a)
    );

    spi_slave #(.WIDTH(12), .MSB_FIRST(1'b0)) dut12 (
        .clk(clk), .rst(rst), .ss(ss_b), .sck(sck), .mosi(mosi), .miso(miso_b),
        .mode(mode), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b),
`ifdef SPI_SLAVE_OVERRUN_EN
        .rx_ready(rx_ready_b), .overrun(ovr_b),
`endif
        .busy(busy_b)
    );

`ifdef SPI_SLAVE_OVERRUN_EN
    assign ack_a = rx_ready_a;
    assign ack_b = rx_ready_b;
`else
    assign ack_a = 1'b1;
    assign ack_b = 1'b1;
    assign ovr_a = 1'b0;
    assign ovr_b = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted rx word is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid_a && ack_a) begin
                vcnt_a++;
                if (q_a.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rx_a unexpected: got %0h expected none", rx_data_a);
                end else begin
                    chk("rx_a", {24'h0, rx_data_a}, q_a.pop_front());
                end
            end
            if (rx_valid_b && ack_b) begin
                vcnt_b++;
                if (q_b.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rx_b unexpected: got %0h expected none", rx_data_b);
                end else begin
                    chk("rx_b", {20'h0, rx_data_b}, q_b.pop_front());
                end
            end
            if (ovr_a || ovr_b) ovr_cnt++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ser(input logic [31:0] w, input int width, input bit msbf);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < width; k++) r[k] = msbf ? w[width-1-k] : w[k];
        return r;
    endfunction

    // mo/mi hold bits in wire order; bit k is the k-th bit on the line.
    task automatic xfer(input int sel, input logic [1:0] m, input int nbits,
                        input logic [63:0] mo, input logic [63:0] mi, input bit raise);
        logic cpol, cpha, mv;
        cpol = m[1];
        cpha = m[0];
        mode = m;
        sck = cpol;
        mosi = 1'b0;
        wait_cyc(H);
        if (sel == 0) ss_a = 1'b0; else ss_b = 1'b0;
        wait_cyc(H);
        for (int k = 0; k < nbits; k++) begin
            if (!cpha) mosi = mo[k];
            wait_cyc(H);
            mv = (sel == 0) ? miso_a : miso_b;
            if (!cpha) chk($sformatf("miso%0d bit%0d", sel, k), {31'h0, mv}, {31'h0, mi[k]});
            sck = ~cpol;
            if (cpha) mosi = mo[k];
            wait_cyc(H);
            mv = (sel == 0) ? miso_a : miso_b;
            if (cpha) chk($sformatf("miso%0d bit%0d", sel, k), {31'h0, mv}, {31'h0, mi[k]});
            sck = cpol;
        end
        if (raise) begin
            wait_cyc(H);
            if (sel == 0) ss_a = 1'b1; else ss_b = 1'b1;
            wait_cyc(H);
            mv = (sel == 0) ? miso_a : miso_b;
            chk($sformatf("miso%0d idle", sel), {31'h0, mv}, 32'h1);
        end
    endtask

    task automatic tx_write_a(input logic [7:0] d);
        @(negedge clk);
        tx_data_a = d;
        tx_valid_a = 1'b1;
        @(posedge clk);
        #1;
        tx_valid_a = 1'b0;
        chk("tx_ready after write", {31'h0, tx_ready_a}, 32'h0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_v;
        #2 rst = 1'b1;
        #1;
        chk("rst miso", {31'h0, miso_a}, 32'h1);
        chk("rst tx_ready", {31'h0, tx_ready_a}, 32'h1);
        chk("rst rx_valid", {31'h0, rx_valid_a}, 32'h0);
        chk("rst rx_data", {24'h0, rx_data_a}, 32'h0);
        chk("rst busy", {31'h0, busy_a}, 32'h0);
        wait_cyc(3);
        @(negedge clk) rst = 1'b0;
        wait_cyc(4);

        // Mode 0, preloaded 0xA5, master sends 0x3C.
        tx_write_a(8'hA5);
        q_a.push_back(32'h3C);
        xfer(0, 2'b00, 8, ser(32'h3C, 8, 1), ser(32'hA5, 8, 1), 1'b1);
        chk("t1 rx_data", {24'h0, rx_data_a}, 32'h3C);

        // Mode 3, back-to-back 0x12, 0x34; only the first tx word supplied.
        tx_write_a(8'h12);
        q_a.push_back(32'h12);
        q_a.push_back(32'h34);
        xfer(0, 2'b11, 16, ser(32'h12, 8, 1) | (ser(32'h34, 8, 1) << 8),
             ser(32'h12, 8, 1) | (ser(32'hFF, 8, 1) << 8), 1'b1);
        chk("t2 tx_ready", {31'h0, tx_ready_a}, 32'h1);

        // Mode 1, aborted after 5 bits, then a full 0x81.
        xfer(0, 2'b01, 5, ser(32'hF0, 8, 1), ser(32'hFF, 8, 1), 1'b1);
        q_a.push_back(32'h81);
        xfer(0, 2'b01, 8, ser(32'h81, 8, 1), ser(32'hFF, 8, 1), 1'b1);
        chk("t3 rx_data", {24'h0, rx_data_a}, 32'h81);

        // 12-bit LSB-first instance receives 0x5A3.
        q_b.push_back(32'h5A3);
        xfer(1, 2'b00, 12, ser(32'h5A3, 12, 0), ser(32'hFFF, 12, 0), 1'b1);
        chk("t4 rx_data_b", {20'h0, rx_data_b}, 32'h5A3);

`ifdef SPI_SLAVE_OVERRUN_EN
        // Receiver stalled: second word dropped, overrun once.
        rx_ready_a = 1'b0;
        q_a.push_back(32'h11);
        xfer(0, 2'b00, 16, ser(32'h11, 8, 1) | (ser(32'h22, 8, 1) << 8),
             ser(32'hFFFF, 16, 1), 1'b1);
        chk("t5 rx_data held", {24'h0, rx_data_a}, 32'h11);
        chk("t5 rx_valid held", {31'h0, rx_valid_a}, 32'h1);
        chk("t5 overrun count", ovr_cnt, 32'h1);
        @(negedge clk) rx_ready_a = 1'b1;
        wait_cyc(2);
        chk("t5 rx_valid cleared", {31'h0, rx_valid_a}, 32'h0);
`endif

        // Reset in the middle of a word.
        tx_write_a(8'h3C);
        xfer(0, 2'b00, 4, ser(32'hC3, 8, 1), ser(32'h3C, 8, 1), 1'b0);
        chk("t6 busy before rst", {31'h0, busy_a}, 32'h1);
        #3 rst = 1'b1;
        #1;
        chk("t6 miso", {31'h0, miso_a}, 32'h1);
        chk("t6 tx_ready", {31'h0, tx_ready_a}, 32'h1);
        chk("t6 rx_valid", {31'h0, rx_valid_a}, 32'h0);
        chk("t6 rx_data", {24'h0, rx_data_a}, 32'h0);
        chk("t6 busy", {31'h0, busy_a}, 32'h0);
        ss_a = 1'b1;
        sck = 1'b0;
        wait_cyc(3);
        @(negedge clk) rst = 1'b0;
        wait_cyc(4);
        q_a.push_back(32'h5A);
        xfer(0, 2'b00, 8, ser(32'h5A, 8, 1), ser(32'hFF, 8, 1), 1'b1);
        chk("t6 rx after rst", {24'h0, rx_data_a}, 32'h5A);

        wait_cyc(4);
`ifdef SPI_SLAVE_OVERRUN_EN
        exp_v = 6;
        chk("overrun total", ovr_cnt, 32'h1);
`else
        exp_v = 5;
        chk("overrun total", ovr_cnt, 32'h0);
`endif
        chk("rx_a count", vcnt_a, exp_v);
        chk("rx_b count", vcnt_b, 32'h1);
        chk("q_a drained", q_a.size(), 32'h0);
        chk("q_b drained", q_b.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the word length in bits (legal range 4..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 shifts the MSB first and 0 shifts the LSB first.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports ss, sck, mosi  input  1 each  raw SPI pins, asynchronous to clk; ss is active low.
REQ-006 SHALL have port miso  output  1  serial data out.
REQ-007 SHALL have port mode  input  2  {CPOL,CPHA}, captured when synced ss falls.
REQ-008 SHALL have ports tx_data  input  WIDTH, tx_valid  input  1, and tx_ready  output  1, forming the transmit handshake.
REQ-009 SHALL have ports rx_data  output  WIDTH and rx_valid  output  1, forming the receive word.
REQ-010 SHALL have port busy  output  1  high while synced ss is low.

Function
REQ-011 SHALL pass ss, sck and mosi through 2-flop synchronizers, then one history flop on sck for edge detection.
- Pin-to-detected-edge latency is 3 clk cycles.
REQ-012 SHALL define the leading edge as sck leaving its CPOL idle level and the trailing edge as sck returning to it.
REQ-013 SHALL sample mosi on the leading edge when CPHA=0 and on the trailing edge when CPHA=1.
REQ-014 SHALL update miso on the opposite edge; when CPHA=0, bit 0 of the word is on miso within 1 cycle of synced ss falling.
REQ-015 SHALL hold a one-entry tx holding register.
- tx_ready = holding register empty.
- A write occurs when tx_valid && tx_ready.
REQ-016 SHALL transfer the holding register into the shift register at synced ss fall and on each word completion.
- If the holding register is empty at that moment, the shift register loads all-ones.
REQ-017 SHALL count bits with a $clog2(WIDTH)-bit counter that wraps to 0 after WIDTH-1 samples.
REQ-018 SHALL, on the WIDTH-th sample, drive rx_data with the assembled word and pulse rx_valid high for exactly 1 cycle.
- rx_data holds its value until the next word completes.
REQ-019 SHALL continue back-to-back words while ss stays low, with no gap cycles required.
REQ-020 SHALL, on synced ss rising mid-word, discard the partial word, produce no rx_valid, reset the counter and drive miso to 1.
REQ-021 SHALL ignore mode changes while busy=1.
REQ-022 SHALL, when the tx write and a word-boundary load occur in the same cycle, load the old holding-register content and then accept the new write.

Reset
REQ-023 SHALL, while rst is high, drive:
- miso=1, tx_ready=1, rx_valid=0, rx_data=0, busy=0;
- counter=0, holding register empty, mode=00;
- all synchronizer flops to their idle values (ss=1, sck=0, mosi=0).
REQ-024 SHALL abort any transfer in progress when rst asserts; the first valid transfer after reset begins at the next synced ss fall.

Configuration
REQ-025 SHALL, with SPI_SLAVE_OVERRUN_EN defined, add rx_ready (input, 1) and overrun (output, 1).
- rx_valid then holds until rx_ready.
- A word completing while rx_valid is high is dropped and overrun pulses for 1 cycle.
REQ-026 SHALL, without SPI_SLAVE_OVERRUN_EN, behave exactly as REQ-018, with neither rx_ready nor overrun present.

Structure
REQ-027 SHALL place the mode encodings (MODE0..MODE3) and the all-ones idle-word function in package spi_pkg.
REQ-028 SHALL instantiate sub-module spi_sync (2-flop synchronizer with parameterised reset value) once for each of ss, sck and mosi.

Verification
REQ-029 SHALL cover: mode 0, WIDTH=8, tx 0xA5 preloaded, master sends 0x3C -> miso shows 1,0,1,0,0,1,0,1; rx_data=0x3C with a single rx_valid pulse.
REQ-030 SHALL cover: mode 3, two back-to-back words 0x12, 0x34 with tx_valid for only the first -> second miso word=0xFF; rx_valid pulses twice.
REQ-031 SHALL cover: ss raised after 5 bits in mode 1 -> no rx_valid; the next full word 0x81 is received correctly.
REQ-032 SHALL cover: MSB_FIRST=0, WIDTH=12, master sends 0x5A3 LSB first -> rx_data=0x5A3.
REQ-033 SHALL cover: with SPI_SLAVE_OVERRUN_EN defined and rx_ready=0, two words sent -> rx_data holds the first word and overrun pulses once.
REQ-034 SHALL cover: rst asserted mid-word -> outputs reach reset values asynchronously with no rx_valid.
